// File: rtl/spi_motor_cmd_rx.sv
// SPI slave (mode 0) that receives 16-bit motor command frames, clamps the
// duties, and holds them for the PWM controller with a watchdog failsafe.
module spi_motor_cmd_rx #(
  parameter logic [6:0]  DUTY_MAX       = 7'd100,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_800_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       load,
  output logic       frame_err,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic logic [6:0] clamp_duty(input logic [6:0] duty);
    return (duty > DUTY_MAX) ? DUTY_MAX : duty;
  endfunction

  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  sdi_sync_q, sdi_sync_d;
  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        m1_sign_q, m1_sign_d, m2_sign_q, m2_sign_d;
  logic [6:0]  m1_duty_q, m1_duty_d, m2_duty_q, m2_duty_d;
  logic        load_q, load_d, frame_err_q, frame_err_d, timeout_q, timeout_d;

  logic sck_rise, cs_fall, cs_rise, sdi_bit;
  logic accept, reject, wd_expire;

  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign sdi_bit   = sdi_sync_q[1];
  assign wd_expire = (wd_cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], sck};
    cs_sync_d  = {cs_sync_q[1:0], cs_n};
    sdi_sync_d = {sdi_sync_q[0], sdi};
  end

  // Frame FSM: SHIFT collects bits until cs_n rises, COMMIT judges the length.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d   = 16'd0;
          bit_cnt_d = 5'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_d = {shift_q[14:0], sdi_bit};
          if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (cs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        if (bit_cnt_q == 5'd16) accept = 1'b1;
        else                    reject = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and watchdog; an accepted frame beats a coincident expiry.
  always_comb begin
    m1_sign_d   = m1_sign_q;
    m1_duty_d   = m1_duty_q;
    m2_sign_d   = m2_sign_q;
    m2_duty_d   = m2_duty_q;
    load_d      = 1'b0;
    frame_err_d = reject;
    timeout_d   = timeout_q;
    wd_cnt_d    = wd_cnt_q;
    if (accept) begin
      m1_sign_d = shift_q[15];
      m1_duty_d = clamp_duty(shift_q[14:8]);
      m2_sign_d = shift_q[7];
      m2_duty_d = clamp_duty(shift_q[6:0]);
      load_d    = 1'b1;
      timeout_d = 1'b0;
      wd_cnt_d  = 24'd0;
    end else if (wd_expire) begin
      if (!timeout_q) begin
        m1_sign_d = 1'b0;
        m1_duty_d = 7'd0;
        m2_sign_d = 1'b0;
        m2_duty_d = 7'd0;
        load_d    = 1'b1;
        timeout_d = 1'b1;
      end
    end else begin
      wd_cnt_d = wd_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b111;
      sdi_sync_q  <= 2'b00;
      state_q     <= IDLE;
      shift_q     <= 16'd0;
      bit_cnt_q   <= 5'd0;
      wd_cnt_q    <= 24'd0;
      m1_sign_q   <= 1'b0;
      m1_duty_q   <= 7'd0;
      m2_sign_q   <= 1'b0;
      m2_duty_q   <= 7'd0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      m1_sign_q   <= m1_sign_d;
      m1_duty_q   <= m1_duty_d;
      m2_sign_q   <= m2_sign_d;
      m2_duty_q   <= m2_duty_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign motor1_sign       = m1_sign_q;
  assign motor1_upperlimit = m1_duty_q;
  assign motor2_sign       = m2_sign_q;
  assign motor2_upperlimit = m2_duty_q;
  assign load              = load_q;
  assign frame_err         = frame_err_q;
  assign timeout           = timeout_q;

endmodule

// File: tb/tb_spi_motor_cmd_rx.sv
// Scoreboard bench for spi_motor_cmd_rx: frames driven at sck = clk/8, expected
// load/frame_err events queued at cs_n rise and matched when the DUT reports them.
module tb_spi_motor_cmd_rx;

  localparam int TO_CYC = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n = 1'b1;
  logic       motor1_sign, motor2_sign, load, frame_err, timeout;
  logic [6:0] motor1_upperlimit, motor2_upperlimit;

  spi_motor_cmd_rx #(.DUTY_MAX(7'd100), .TIMEOUT_CYCLES(24'd1000)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .load(load), .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic       to;
    logic       lat;
    logic       s1;
    logic [6:0] d1;
    logic       s2;
    logic [6:0] d2;
    int         cs_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   last_load_cyc = 0;
  logic       a_s1 = 0, a_s2 = 0, a_to = 0;
  logic [6:0] a_d1 = 0, a_d2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [6:0] ref_duty(input logic [6:0] d);
    return (d > 7'd100) ? 7'd100 : d;
  endfunction

  // Monitor: every load/frame_err pulse must match the head of the queue;
  // between events the outputs must hold the last applied values.
  always @(negedge clk) begin
    if (reset) begin
      if (load || frame_err) begin
        if (q.size() == 0) begin
          check_val("spurious_event", {30'd0, load, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_val("frame_err", frame_err, e.err);
          check_val("load", load, !e.err);
          check_val("m1_sign", motor1_sign, e.s1);
          check_val("m1_duty", motor1_upperlimit, e.d1);
          check_val("m2_sign", motor2_sign, e.s2);
          check_val("m2_duty", motor2_upperlimit, e.d2);
          check_val("timeout", timeout, e.to);
          if (e.lat) check_val("latency", cyc - e.cs_cyc, 4);
          if (e.to)  check_val("wd_gap", cyc - last_load_cyc, TO_CYC);
          a_s1 = e.s1; a_d1 = e.d1; a_s2 = e.s2; a_d2 = e.d2; a_to = e.to;
        end
        if (load) last_load_cyc = cyc;
      end else begin
        check_val("hold", {motor1_sign, motor1_upperlimit, motor2_sign, motor2_upperlimit, timeout},
                  {a_s1, a_d1, a_s2, a_d2, a_to});
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits);
    exp_t e;
    cs_n = 1'b0;
    clk_wait(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      clk_wait(4);
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
    end
    clk_wait(4);
    e.lat = 1'b1;
    e.to  = 1'b0;
    e.cs_cyc = cyc;
    if (nbits == 16) begin
      e.err = 1'b0;
      e.s1 = data[15]; e.d1 = ref_duty(data[14:8]);
      e.s2 = data[7];  e.d2 = ref_duty(data[6:0]);
    end else begin
      e.err = 1'b1;
      e.s1 = a_s1; e.d1 = a_d1; e.s2 = a_s2; e.d2 = a_d2;
      e.to = a_to;
    end
    q.push_back(e);
    cs_n = 1'b1;
    clk_wait(16);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() != 0; i++) clk_wait(1);
    check_val("drain", q.size(), 0);
    clk_wait(4);
  endtask

  task automatic check_reset_state();
    check_val("rst_m1_sign", motor1_sign, 0);
    check_val("rst_m1_duty", motor1_upperlimit, 0);
    check_val("rst_m2_sign", motor2_sign, 0);
    check_val("rst_m2_duty", motor2_upperlimit, 0);
    check_val("rst_load", load, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_timeout", timeout, 0);
  endtask

  initial begin
    exp_t e;
    clk_wait(5);
    reset = 1'b1;
    clk_wait(2);
    check_reset_state();

    send_frame(32'hB205, 16);
    wait_drain(100);
    send_frame(32'h7FE5, 16);
    wait_drain(100);

    send_frame(32'h0A0A, 16);
    wait_drain(100);
    send_frame(32'h1234, 15);
    wait_drain(100);
    send_frame(32'h1ABCD, 17);
    wait_drain(100);

    e.err = 1'b0; e.to = 1'b1; e.lat = 1'b0; e.cs_cyc = 0;
    e.s1 = 1'b0; e.d1 = 7'd0; e.s2 = 1'b0; e.d2 = 7'd0;
    q.push_back(e);
    wait_drain(1500);
    clk_wait(50);
    send_frame(32'h1494, 16);
    wait_drain(100);

    // Abort a frame after 8 bits with reset, then release cleanly.
    cs_n = 1'b0;
    clk_wait(4);
    for (int i = 7; i >= 0; i--) begin
      sdi = i[0];
      clk_wait(4);
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
    end
    reset = 1'b0;
    a_s1 = 0; a_d1 = 0; a_s2 = 0; a_d2 = 0; a_to = 0;
    clk_wait(3);
    cs_n = 1'b1;
    clk_wait(3);
    reset = 1'b1;
    clk_wait(8);
    check_reset_state();
    send_frame(32'h0102, 16);
    wait_drain(100);

    send_frame(32'h2233, 16);
    send_frame(32'h8C45, 16);
    wait_drain(100);
    check_val("b2b_m1_duty", motor1_upperlimit, 12);
    check_val("b2b_m2_duty", motor2_upperlimit, 69);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/spi_motor_cmd_rx.md
Name: spi_motor_cmd_rx

Overview:
- SPI slave receiver that takes motor commands from the MCU and drives the PWM motor controller directly downstream.
- Deserialises 16-bit frames into sign plus 7-bit duty per motor.
- Clamps duty to the PWM period (100), holds the values, and pulses load on each accepted frame.
- A watchdog forces both motors to zero duty if the MCU stops sending frames.

Parameters:
- DUTY_MAX, 7'd100: duty clamp ceiling; must match the controller's counter limit.
- TIMEOUT_CYCLES, 24'd4_800_000: clk cycles without an accepted frame before failsafe (100 ms at 48 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0, must be at most clk/8.
- sdi  input  1  SPI data from MCU, MSB first.
- cs_n  input  1  SPI chip select, active low; one frame per low period.
- motor1_sign  output  1  direction for motor 1.
- motor1_upperlimit  output  7  duty for motor 1, range 0..DUTY_MAX.
- motor2_sign  output  1  direction for motor 2.
- motor2_upperlimit  output  7  duty for motor 2, range 0..DUTY_MAX.
- load  output  1  one-cycle pulse when new motor values appear.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- timeout  output  1  high while failsafe is active.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0.
  - Shift register, bit counter and watchdog counter clear.
  - A partial frame in progress is discarded.
- Synchronisation:
  - sck, sdi and cs_n each pass through two flip-flops.
  - A third register per signal provides edge detection.
  - Nothing is used unsynchronised.
- States: IDLE, SHIFT, COMMIT.
  - IDLE: on synchronised cs_n falling edge, clear bit_cnt and shift register, go to SHIFT.
  - SHIFT, sck rising edge: shift sdi into a 16-bit register, MSB first; bit_cnt increments and saturates at 17.
  - SHIFT, sck falling edge: ignored.
  - SHIFT, cs_n rising edge: go to COMMIT.
  - COMMIT, lasts exactly one cycle.
    - If bit_cnt==16, the frame is accepted. Bit15 goes to motor1_sign and bits14:8 to motor1 duty; bit7 goes to motor2_sign and bits6:0 to motor2 duty.
    - If bit_cnt!=16, covering both short and long frames: outputs are unchanged and frame_err pulses.
    - Always returns to IDLE.
- Timing of an accepted frame:
  - Outputs update on the clk edge ending COMMIT.
  - load is high for exactly that one following cycle.
  - Outputs are stable in every other cycle.
- Clamp: a received duty in the range DUTY_MAX+1..127 is output as DUTY_MAX; the sign bit is kept.
- Watchdog:
  - The counter increments every cycle.
  - It clears on an accepted frame; rejected frames do not clear it.
  - When the count reaches TIMEOUT_CYCLES-1:
    - Both duties are forced to 0 and both signs to 0.
    - timeout is set and load pulses once.
    - The counter holds.
  - timeout clears on the next accepted frame, whose values apply normally.
- Simultaneous events: if an accepted frame commits in the same cycle the watchdog would expire, the frame wins. The counter clears and timeout stays or goes to 0.
- cs_n falling again before COMMIT completes is impossible, since COMMIT is one cycle and the minimum SPI spacing is larger. No special handling is required.
- Latency, cs_n pin rising to load high: 4 clk cycles.
  - 2 cycles synchroniser.
  - 1 cycle edge detect / COMMIT.
  - 1 cycle output register.
- An sck edge while cs_n is high is ignored.

Test Plan:
- Reset, then frame 0xB2_05 (motor1 sign 1, duty 0x32=50; motor2 sign 0, duty 5) at sck=clk/8:
  - Expect load one cycle, 4 clk after cs_n rises.
  - motor1_sign=1, motor1_upperlimit=50, motor2_sign=0, motor2_upperlimit=5.
  - frame_err=0.
- Frame 0x7F_E5 (duties 127 and 101):
  - Expect motor1_upperlimit=100, motor2_upperlimit=100.
  - motor1_sign=0, motor2_sign=1.
  - load pulses once.
- Frames of 15 and 17 bits after a valid 0x0A_0A:
  - Each gives a frame_err pulse and no load.
  - Outputs stay at 10/10.
- TIMEOUT_CYCLES=1000, no frames after 0x0A_0A:
  - Exactly 1000 cycles after that frame's load, timeout=1.
  - Duties 0, signs 0, one load pulse.
  - Next frame 0x14_94 restores duty 20/20, sign 0/1, and sets timeout=0.
- reset asserted mid-frame after 8 bits:
  - Outputs 0, no load.
  - The following complete frame 0x01_02 is accepted with duties 1 and 2.
- Back-to-back frames with 2 sck periods of cs_n high between them:
  - Both are accepted, with two load pulses.
  - Final outputs equal the second frame.
